data_write_arbiter: RTL and testbench

Shares the register file's single write port between three writeback sources: ALU result (requester 0), memory load (requester 1) and immediate/move (requester 2). Each cycle it grants at most one valid request and registers the winner's address and data into the write stage. It drives the address/enable pair into the register-file write decoder and the data onto the register-file write bus. It also exports a one-hot busy map so the issue logic can stall reads of a register with a write in flight.

---
 rtl/data_write_arbiter.sv | 94 +++++++++
 tb/tb_data_write_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_write_arbiter.sv
// Write-port arbiter: three writeback sources share one register-file write port.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module data_write_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            Req_valid,
   input  logic [3*ADDR_W-1:0]   Req_addr,
   input  logic [3*DATA_W-1:0]   Req_data,
   output logic [2:0]            Req_ready,
   input  logic                  Hold,
   output logic [ADDR_W-1:0]     Data_write_address_,
   output logic                  Enable_write_,
   output logic [DATA_W-1:0]     Write_data,
   output logic [2**ADDR_W-1:0]  Pending
);
   localparam int NREQ = 3;
   localparam int NREG = 2**ADDR_W;

   logic [ADDR_W-1:0] req_addr_a [NREQ];
   logic [DATA_W-1:0] req_data_a [NREQ];
   logic [NREQ-1:0]   grant;
   logic [1:0]        win_idx;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign req_addr_a[i] = Req_addr[i*ADDR_W +: ADDR_W];
      assign req_data_a[i] = Req_data[i*DATA_W +: DATA_W];
   end

`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0] last;
   logic [1:0] idx;
   logic       found;

   // Walk the three requesters starting just after the last winner.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = (last == 2'd2) ? 2'd0 : last + 2'd1;
      if (!rst && !Hold) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!found && Req_valid[idx]) begin
               grant[idx] = 1'b1;
               found      = 1'b1;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         last <= 2'd2;
      else if (|grant)
         last <= win_idx;
   end
`else
   always_comb begin
      grant = '0;
      if (!rst && !Hold) begin
         if (Req_valid[0])      grant[0] = 1'b1;
         else if (Req_valid[1]) grant[1] = 1'b1;
         else if (Req_valid[2]) grant[2] = 1'b1;
      end
   end
`endif

   assign Req_ready = grant;
   assign win_idx   = grant[1] ? 2'd1 : (grant[2] ? 2'd2 : 2'd0);
   assign win_addr  = req_addr_a[win_idx];
   assign win_data  = req_data_a[win_idx];

   // Single write-stage slot, refilled every cycle; address/data hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         Enable_write_       <= 1'b0;
         Data_write_address_ <= '0;
         Write_data          <= '0;
         Pending             <= '0;
      end else begin
         Enable_write_ <= |grant;
         Pending       <= '0;
         if (|grant) begin
            Data_write_address_ <= win_addr;
            Write_data          <= win_data;
            Pending             <= {{(NREG-1){1'b0}}, 1'b1} << win_addr;
         end
      end
   end
endmodule

// File: tb/tb_data_write_arbiter.sv
// Self-checking bench for data_write_arbiter: directed scenarios then randomized
// traffic against a behavioural model of the grant rules and write stage.
module tb_data_write_arbiter;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int NREG   = 2**ADDR_W;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [2:0]           Req_valid;
   logic [3*ADDR_W-1:0]  Req_addr;
   logic [3*DATA_W-1:0]  Req_data;
   logic [2:0]           Req_ready;
   logic                 Hold;
   logic [ADDR_W-1:0]    Data_write_address_;
   logic                 Enable_write_;
   logic [DATA_W-1:0]    Write_data;
   logic [NREG-1:0]      Pending;

   data_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .Req_valid(Req_valid), .Req_addr(Req_addr),
      .Req_data(Req_data), .Req_ready(Req_ready), .Hold(Hold),
      .Data_write_address_(Data_write_address_), .Enable_write_(Enable_write_),
      .Write_data(Write_data), .Pending(Pending)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // behavioural model
   int              m_last;
   bit              m_en;
   int              m_addr;
   int              m_data;
   logic [DATA_W-1:0] dreg [NREG];
   logic [2:0]      last_ready;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick();
      int i;
      if (rst || Hold) return -1;
      for (int k = 0; k < 3; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
         i = (m_last + 1 + k) % 3;
`else
         i = k;
`endif
         if (Req_valid[i]) return i;
      end
      return -1;
   endfunction

   // One clock: check grant mid-cycle, advance, check the write stage.
   task automatic cycle();
      int g;
      int ga, gd;
      #1;
      g = pick();
      chk("ready", {29'd0, Req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
      if (Enable_write_) dreg[Data_write_address_] = Write_data;
      last_ready = Req_ready;
      ga = (g < 0) ? 0 : int'(Req_addr[g*ADDR_W +: ADDR_W]);
      gd = (g < 0) ? 0 : int'(Req_data[g*DATA_W +: DATA_W]);
      @(posedge clk);
      #1;
      if (rst) begin
         m_en = 0; m_addr = 0; m_data = 0; m_last = 2;
      end else if (g >= 0) begin
         m_en = 1; m_addr = ga; m_data = gd; m_last = g;
      end else begin
         m_en = 0;
      end
      chk("enable",  {31'd0, Enable_write_}, {31'd0, m_en});
      chk("address", {29'd0, Data_write_address_}, m_addr);
      chk("data",    {24'd0, Write_data}, m_data);
      chk("pending", {24'd0, Pending}, m_en ? (32'd1 << m_addr) : 32'd0);
   endtask

   task automatic set_req(input int i, input bit v, input int a, input int d);
      Req_valid[i] = v;
      Req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
      Req_data[i*DATA_W +: DATA_W] = DATA_W'(d);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      m_last = 2; m_en = 0; m_addr = 0; m_data = 0;
      for (int r = 0; r < NREG; r++) dreg[r] = '0;
      rst = 1'b1; Hold = 1'b0;
      Req_valid = 3'b111; Req_addr = '0; Req_data = '0;

      // reset with all requesters valid
      cycle();
      cycle();
      chk("rst_ready", {29'd0, last_ready}, 32'd0);
      chk("rst_en", {31'd0, Enable_write_}, 32'd0);
      chk("rst_pend", {24'd0, Pending}, 32'd0);
      rst = 1'b0; Req_valid = 3'b000;
      cycle();

      // single write from requester 1
      set_req(1, 1, 5, 8'hA7);
      cycle();
      chk("single_ready", {29'd0, last_ready}, 32'h2);
      chk("single_addr", {29'd0, Data_write_address_}, 32'd5);
      chk("single_data", {24'd0, Write_data}, 32'hA7);
      chk("single_pend", {24'd0, Pending}, 32'h20);
      Req_valid = 3'b000;
      cycle();
      chk("single_idle_en", {31'd0, Enable_write_}, 32'd0);
      chk("single_hold_data", {24'd0, Write_data}, 32'hA7);

      // contention, all three valid for three cycles after reset
      do_reset();
      set_req(0, 1, 1, 8'h01); set_req(1, 1, 3, 8'h02); set_req(2, 1, 6, 8'h03);
      cycle();
      chk("cont_g0", {29'd0, last_ready}, 32'h1);
      cycle();
`ifdef ARB_ROUND_ROBIN_EN
      chk("cont_g1", {29'd0, last_ready}, 32'h2);
`else
      chk("cont_g1", {29'd0, last_ready}, 32'h1);
`endif
      cycle();
`ifdef ARB_ROUND_ROBIN_EN
      chk("cont_g2", {29'd0, last_ready}, 32'h4);
      chk("cont_w2", {24'd0, Write_data}, 32'h03);
`else
      chk("cont_g2", {29'd0, last_ready}, 32'h1);
      chk("cont_w2", {24'd0, Write_data}, 32'h01);
`endif
      Req_valid = 3'b000;
      cycle();

      // same-address collision
      do_reset();
      set_req(0, 1, 2, 8'h11); set_req(2, 1, 2, 8'h22);
      cycle();
      chk("coll_first", {24'd0, Write_data}, 32'h11);
      Req_valid[0] = 1'b0;
      cycle();
      chk("coll_second", {24'd0, Write_data}, 32'h22);
      Req_valid = 3'b000;
      cycle();
      chk("coll_final", {24'd0, dreg[2]}, 32'h22);

      // hold does not cancel an accepted write
      set_req(1, 1, 4, 8'h5C);
      cycle();
      Req_valid = 3'b000; set_req(2, 1, 7, 8'h3E); Hold = 1'b1;
      chk("hold_issue_en", {31'd0, Enable_write_}, 32'd1);
      cycle(); cycle(); cycle();
      chk("hold_ready", {29'd0, last_ready}, 32'd0);
      Hold = 1'b0;
      cycle();
      chk("hold_release_ready", {29'd0, last_ready}, 32'h4);
      chk("hold_release_data", {24'd0, Write_data}, 32'h3E);
      Req_valid = 3'b000;
      cycle();

      // reset mid-operation with traffic pending
      set_req(0, 1, 1, 8'hAA); set_req(1, 1, 2, 8'hBB); set_req(2, 1, 3, 8'hCC);
      cycle();
      rst = 1'b1;
      cycle();
      chk("midrst_en", {31'd0, Enable_write_}, 32'd0);
      rst = 1'b0;
      cycle();
      chk("midrst_restart", {29'd0, last_ready}, 32'h1);
      Req_valid = 3'b000;
      cycle();

      // randomized traffic; requesters hold their request until granted
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 3; i++)
            if (!Req_valid[i] || last_ready[i])
               set_req(i, ($urandom_range(0, 9) < 6), $urandom_range(0, NREG-1), $urandom_range(0, 255));
         Hold = ($urandom_range(0, 9) < 2);
         rst  = ($urandom_range(0, 49) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
